sprite_fetch_sched: RTL and testbench

- Per-frame scheduler that reads the sprite descriptor table (x, y, glyph index per sprite) from system RAM.
- Shares the single system RAM read port with other masters through a req/gnt handshake.
- Fetch runs during vertical sync; descriptors are written into the sprite register file that the glyph address generator reads during active display.
- Replaces fixed per-sprite fetch states with a counter-driven, stall-tolerant, pipelined fetch for NUM_SPRITES sprites.

---
 rtl/sprite_fetch_sched.sv | 130 +++++++++++++
 tb/tb_sprite_fetch_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_sched.sv
`default_nettype none
// ============================================================================
// sprite_fetch_sched : vsync-triggered, grant-stalled sprite descriptor fetch
// Rev 1.0
// ============================================================================
module sprite_fetch_sched #(
   parameter int                        SYS_DATA_WIDTH   = 18,
   parameter int                        SYS_ADDR_WIDTH   = 16,
   parameter logic [SYS_ADDR_WIDTH-1:0] BASE_ADDR        = 16'h1000,
   parameter int                        NUM_SPRITES      = 4,
   parameter int                        LOG2_NUM_SPRITES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        vsync,
   input  logic                        mem_gnt,
   input  logic [SYS_DATA_WIDTH-1:0]   sys_data,
   output logic                        mem_req,
   output logic [SYS_ADDR_WIDTH-1:0]   sys_addr,
   output logic                        wr_en,
   output logic [LOG2_NUM_SPRITES-1:0] wr_idx,
   output logic [1:0]                  wr_field,
   output logic [SYS_DATA_WIDTH-1:0]   wr_data,
   output logic                        table_valid,
   output logic                        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [LOG2_NUM_SPRITES-1:0] c_LAST_IDX = LOG2_NUM_SPRITES'(NUM_SPRITES - 1);
   localparam logic [1:0]                  c_LAST_FLD = 2'd2;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic                          r_vsync_d;
   logic [LOG2_NUM_SPRITES-1:0]   r_idx;
   logic [LOG2_NUM_SPRITES-1:0]   w_idx_nxt;
   logic [1:0]                    r_fld;
   logic [1:0]                    w_fld_nxt;
   logic [SYS_ADDR_WIDTH-1:0]     w_addr_nxt;
   logic                          w_trig;
   logic                          w_issue;
   logic                          w_last;
   logic                          w_req_nxt;
   logic                          w_tv_nxt;
   logic                          w_busy_nxt;

   assign w_trig  = r_vsync_d & ~vsync;
   assign w_issue = (r_state == S_FETCH) & mem_req & mem_gnt;
   assign w_last  = (r_idx == c_LAST_IDX) && (r_fld == c_LAST_FLD);
   assign wr_data = sys_data;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_fld_nxt   = r_fld;
      w_tv_nxt    = table_valid;
      w_addr_nxt  = sys_addr;
      case (r_state)
         S_IDLE: w_state_nxt = S_IDLE;
         S_FETCH: begin
            if (w_issue) begin
               if (r_fld == c_LAST_FLD) begin
                  w_fld_nxt = 2'd0;
                  w_idx_nxt = r_idx + 1'b1;
               end else begin
                  w_fld_nxt = r_fld + 2'd1;
               end
               if (w_last) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_IDLE;
            w_tv_nxt    = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A new frame start always wins, even over the last-word transition
      if (w_trig) begin
         w_state_nxt = S_FETCH;
         w_idx_nxt   = '0;
         w_fld_nxt   = 2'd0;
         w_tv_nxt    = 1'b0;
      end
      // Address only moves when the word pointer moves, so it is quiet in IDLE
      if (w_issue || w_trig) begin
         w_addr_nxt = BASE_ADDR + (SYS_ADDR_WIDTH'(w_idx_nxt) << 2) + SYS_ADDR_WIDTH'(w_fld_nxt);
      end
      w_req_nxt  = (w_state_nxt == S_FETCH);
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_vsync_d   <= 1'b1;
         r_idx       <= '0;
         r_fld       <= 2'd0;
         mem_req     <= 1'b0;
         sys_addr    <= '0;
         wr_en       <= 1'b0;
         wr_idx      <= '0;
         wr_field    <= 2'd0;
         table_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_vsync_d   <= vsync;
         r_idx       <= w_idx_nxt;
         r_fld       <= w_fld_nxt;
         mem_req     <= w_req_nxt;
         sys_addr    <= w_addr_nxt;
         wr_en       <= w_issue;
         table_valid <= w_tv_nxt;
         busy        <= w_busy_nxt;
         if (w_issue) begin
            wr_idx   <= r_idx;
            wr_field <= r_fld;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_sched.sv
`default_nettype none
// ============================================================================
// tb_sprite_fetch_sched : scoreboard bench for the sprite descriptor fetcher
// Rev 1.0
// ============================================================================
module tb_sprite_fetch_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vsync = 1'b1;
   logic        mem_gnt = 1'b1;
   logic [17:0] sys_data = '0;
   logic        mem_req;
   logic [15:0] sys_addr;
   logic        wr_en;
   logic [1:0]  wr_idx;
   logic [1:0]  wr_field;
   logic [17:0] wr_data;
   logic        table_valid;
   logic        busy;

   sprite_fetch_sched dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .mem_gnt    (mem_gnt),
      .sys_data   (sys_data),
      .mem_req    (mem_req),
      .sys_addr   (sys_addr),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_field   (wr_field),
      .wr_data    (wr_data),
      .table_valid(table_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [17:0] ram(input logic [15:0] a);
      return {a[1:0], a ^ 16'hA5C3};
   endfunction

   function automatic logic [15:0] exp_addr(input int k);
      return 16'(16'h1000 + 4 * (k / 3) + (k % 3));
   endfunction

   // RAM model: read data appears the cycle after a granted request
   always @(posedge clk) begin
      if (mem_req && mem_gnt) sys_data <= ram(sys_addr);
      else                    sys_data <= 18'h3FFFF;
   end

   // Scoreboard and expected-control model, evaluated mid-cycle
   logic [21:0] q[$];
   bit          mon_en    = 0;
   bit          exp_wr    = 0;
   bit          fetching  = 0;
   bit          draining  = 0;
   bit          tv_exp    = 0;
   bit          vs_d      = 1;
   int          k         = 0;
   int          nwr       = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         logic [21:0] e;
         bit trig, push, last;
         check("wr_en", wr_en, exp_wr);
         if (wr_en && q.size() > 0) begin
            e = q.pop_front();
            check("wr_word", {wr_idx, wr_field, wr_data}, e);
            nwr++;
         end
         check("mem_req", mem_req, fetching);
         check("busy", busy, fetching || draining);
         check("table_valid", table_valid, tv_exp);
         if (mem_req) check("sys_addr", sys_addr, exp_addr(k));

         trig   = vs_d && !vsync && !reset;
         push   = mem_req && mem_gnt && !reset;
         last   = push && (k == 11);
         exp_wr = push;
         if (push) begin
            q.push_back({2'(k / 3), 2'(k % 3), ram(exp_addr(k))});
            k++;
         end
         if (reset) begin
            fetching = 0; draining = 0; tv_exp = 0; k = 0; exp_wr = 0;
            q.delete();
         end else if (trig) begin
            fetching = 1; draining = 0; tv_exp = 0; k = 0;
         end else if (last) begin
            fetching = 0; draining = 1;
         end else if (draining) begin
            draining = 0; tv_exp = 1;
         end
         vs_d = reset ? 1'b1 : vsync;
      end
   end

   task automatic fall();
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b0;
   endtask

   task automatic wait_done(input bit toggle, input int limit);
      int  n = 0;
      bit  seen_busy = 0;
      while (n < limit && !(seen_busy && table_valid)) begin
         @(posedge clk); #1;
         if (toggle) mem_gnt = ~mem_gnt;
         @(negedge clk);
         if (busy) seen_busy = 1;
         n++;
      end
      check("done_in_time", (n < limit), 1'b1);
      mem_gnt = 1'b1;
   endtask

   logic [15:0] addr_tbl [12] = '{16'h1000, 16'h1001, 16'h1002, 16'h1004, 16'h1005, 16'h1006,
                                  16'h1008, 16'h1009, 16'h100A, 16'h100C, 16'h100D, 16'h100E};

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1 mon_en = 1;
      @(negedge clk);
      check("rst_sys_addr", sys_addr, 16'h0000);
      check("rst_wr_idx", wr_idx, 2'd0);
      check("rst_wr_field", wr_field, 2'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Full-rate fetch with fixed-latency expectations
      base = nwr;
      #1 vsync = 1'b0;
      @(posedge clk);
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         check("s1_req", mem_req, (c <= 11));
         check("s1_busy", busy, (c <= 12));
         check("s1_tv", table_valid, (c == 13));
         check("s1_wr_en", wr_en, (c >= 1 && c <= 12));
         if (c <= 11) check("s1_addr", sys_addr, addr_tbl[c]);
      end
      check("s1_writes", nwr - base, 12);

      // Grant on alternate cycles
      base = nwr;
      fall();
      wait_done(1'b1, 200);
      check("s2_writes", nwr - base, 12);

      // Restart on the fifth issue
      base = nwr;
      fall();
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("s3_wr_en_w4", wr_en, 1'b1);
      check("s3_w4_slot", {wr_idx, wr_field}, {2'd1, 2'd1});
      check("s3_addr_restart", sys_addr, 16'h1000);
      check("s3_tv", table_valid, 1'b0);
      wait_done(1'b0, 100);
      check("s3_writes", nwr - base, 17);

      // Reset while word 6 is due
      base = nwr;
      fall();
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1; vsync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("s4_req", mem_req, 1'b0);
      check("s4_wr_en", wr_en, 1'b0);
      check("s4_tv", table_valid, 1'b0);
      check("s4_busy", busy, 1'b0);
      check("s4_partial", nwr - base, 6);
      @(posedge clk); #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("s4_quiet", nwr - base, 6);
      base = nwr;
      fall();
      wait_done(1'b0, 100);
      check("s4_refetch", nwr - base, 12);

      // vsync held low long after completion
      base = nwr;
      fall();
      wait_done(1'b0, 100);
      repeat (1000) @(posedge clk);
      @(negedge clk);
      check("s5_writes", nwr - base, 12);
      check("s5_tv", table_valid, 1'b1);
      check("s5_req", mem_req, 1'b0);

      // Grant withheld for 50 cycles
      base = nwr;
      mem_gnt = 1'b0;
      fall();
      repeat (50) @(negedge clk);
      check("s6_nowr", nwr - base, 0);
      check("s6_addr", sys_addr, 16'h1000);
      check("s6_req", mem_req, 1'b1);
      @(posedge clk); #1 mem_gnt = 1'b1;
      wait_done(1'b0, 100);
      check("s6_writes", nwr - base, 12);
      check("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
